// File: rtl/load_ext_pkg.sv
// Shared encodings and width helpers for the load-data unit.
// The LOAD_EXT_SPLIT_EN build option is consumed by load_ext_unit.
package load_ext_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_RESP
  } state_e;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic logic [3:0] nbytes_of(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/load_ext_unit_lane_ext.sv
// Combinational byte-lane selector and sign/zero extender over a two-beat window.
// Result byte k is window byte (off+k) for k < nbytes, fill above.
module lane_ext
  import load_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = lane_bits(DATA_W)
) (
  input  logic [2*DATA_W-1:0] beats,
  input  logic [OFF_W-1:0]    off,
  input  logic [1:0]          size,
  input  logic                is_signed,
  output logic [DATA_W-1:0]   result
);

  localparam int LANES = lanes_of(DATA_W);

  logic [DATA_W-1:0] shifted;
  logic [3:0]        nbytes;
  logic              msb;
  logic [7:0]        fill;

  assign shifted = DATA_W'(beats >> {off, 3'b000});
  assign nbytes  = nbytes_of(size);

  always_comb begin
    msb = shifted[7];
    case (size)
      SZ_BYTE: msb = shifted[7];
      SZ_HALF: msb = shifted[15];
      SZ_WORD: msb = shifted[31];
      default: msb = shifted[DATA_W-1];
    endcase
  end

  assign fill = {8{msb & is_signed}};

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [3:0] LANE_IDX = 4'(gi);
      assign result[8*gi +: 8] = (LANE_IDX < nbytes) ? shifted[8*gi +: 8] : fill;
    end
  endgenerate

endmodule

// File: rtl/load_ext_unit.sv
// Load-data unit: issues one or two aligned reads, then aligns and extends the result.
// Define LOAD_EXT_SPLIT_EN to serve misaligned loads (two beats when crossing a word).
module load_ext_unit
  import load_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int LANES = lanes_of(DATA_W);
  localparam int OFF_W = lane_bits(DATA_W);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_nbytes;
  logic              req_illegal;
  logic              req_misaligned;
  logic              req_err;
  logic              req_fire;
  logic              final_beat;
  logic [DATA_W-1:0] ext_beat0, ext_beat1, ext_result;

  assign req_off        = req_addr[OFF_W-1:0];
  assign req_nbytes     = nbytes_of(req_size);
  assign req_illegal    = {req_nbytes, 3'b000} > 7'(DATA_W);
  assign req_misaligned = (4'(req_off) & (req_nbytes - 4'd1)) != 4'd0;
`ifdef LOAD_EXT_SPLIT_EN
  assign req_err        = req_illegal;
`else
  assign req_err        = req_illegal | req_misaligned;
`endif
  assign req_fire       = (state_q == ST_IDLE) && req_valid;

`ifdef LOAD_EXT_SPLIT_EN
  logic [DATA_W-1:0] beat0_q;
  logic              crossing;
  assign crossing   = (5'(off_q) + 5'(nbytes_of(size_q))) > 5'(LANES);
  assign final_beat = mem_rd_valid &&
                      (((state_q == ST_WAIT0) && !crossing) || (state_q == ST_WAIT1));
`else
  assign final_beat = mem_rd_valid && (state_q == ST_WAIT0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = req_err ? ST_RESP : ST_ISSUE0;
      ST_ISSUE0: state_d = ST_WAIT0;
`ifdef LOAD_EXT_SPLIT_EN
      ST_WAIT0:  if (mem_rd_valid) state_d = crossing ? ST_ISSUE1 : ST_RESP;
      ST_ISSUE1: state_d = ST_WAIT1;
      ST_WAIT1:  if (mem_rd_valid) state_d = ST_RESP;
`else
      ST_WAIT0:  if (mem_rd_valid) state_d = ST_RESP;
`endif
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    mem_rd_en = (state_q == ST_ISSUE0) || (state_q == ST_ISSUE1);
    rsp_valid = (state_q == ST_RESP);
  end

  // The final beat is extracted straight from the bus so the response registers one cycle later.
  always_comb begin
    ext_beat0 = mem_rd_data;
    ext_beat1 = '0;
`ifdef LOAD_EXT_SPLIT_EN
    if (state_q == ST_WAIT1) begin
      ext_beat0 = beat0_q;
      ext_beat1 = mem_rd_data;
    end
`endif
  end

  lane_ext #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_lane_ext (
    .beats     ({ext_beat1, ext_beat0}),
    .off       (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .result    (ext_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q      <= '0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      mem_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef LOAD_EXT_SPLIT_EN
      beat0_q    <= '0;
`endif
    end else begin
      if (req_fire) begin
        off_q    <= req_off;
        size_q   <= req_size;
        signed_q <= req_signed;
        if (req_err) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end else begin
          mem_addr_q <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          rsp_err_q  <= 1'b0;
        end
      end
      if (final_beat) rsp_data_q <= ext_result;
`ifdef LOAD_EXT_SPLIT_EN
      if ((state_q == ST_WAIT0) && mem_rd_valid) begin
        beat0_q <= mem_rd_data;
        if (crossing) mem_addr_q <= mem_addr_q + ADDR_W'(LANES);
      end
`endif
    end
  end

  assign mem_addr = mem_addr_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_ext_unit.sv
// Directed bench for load_ext_unit: 32-bit instance for most vectors, 64-bit for dword loads.
module tb_load_ext_unit;
  import load_ext_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid, req_ready, req_signed;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        mem_rd_en, mem_rd_valid;
  logic [31:0] mem_addr, mem_rd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;

  logic        w_req_valid, w_req_ready, w_req_signed;
  logic [31:0] w_req_addr;
  logic [1:0]  w_req_size;
  logic        w_rd_en, w_rd_valid;
  logic [31:0] w_addr;
  logic [63:0] w_rd_data;
  logic        w_rsp_valid, w_rsp_ready, w_rsp_err;
  logic [63:0] w_rsp_data;

  load_ext_unit #(.DATA_W(32), .ADDR_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  load_ext_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_addr(w_req_addr),
    .req_size(w_req_size), .req_signed(w_req_signed),
    .mem_rd_en(w_rd_en), .mem_addr(w_addr), .mem_rd_data(w_rd_data),
    .mem_rd_valid(w_rd_valid),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data), .rsp_err(w_rsp_err)
  );

  int compared = 0;
  int mismatched = 0;

  logic        mem_auto;
  logic        pend32, pend64;
  logic [31:0] pend_addr32, pend_addr64;
  int          rd_cnt;
  logic [31:0] rd_log [4];
  logic [31:0] w100;

  function automatic logic [31:0] word32(input logic [31:0] a);
    case (a)
      32'h100: return w100;
      32'h200: return 32'h44332211;
      32'h204: return 32'h88776655;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic [63:0] word64(input logic [31:0] a);
    if (a == 32'h1000) return 64'h8000000000000001;
    return 64'h0;
  endfunction

  // One clock; memories answer the cycle after a read strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_rd_valid = pend32;
    mem_rd_data  = pend32 ? word32(pend_addr32) : 32'h0;
    pend32       = mem_rd_en && mem_auto;
    pend_addr32  = mem_addr;
    if (mem_rd_en) begin
      if (rd_cnt < 4) rd_log[rd_cnt] = mem_addr;
      rd_cnt++;
    end
    w_rd_valid  = pend64;
    w_rd_data   = pend64 ? word64(pend_addr64) : 64'h0;
    pend64      = w_rd_en && mem_auto;
    pend_addr64 = w_addr;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start32(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         output int lat);
    rd_cnt     = 0;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish32();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic load64(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                        output int lat, output logic [63:0] d);
    w_req_addr   = a;
    w_req_size   = sz;
    w_req_signed = sg;
    w_req_valid  = 1'b1;
    tick();
    w_req_valid = 1'b0;
    lat = 1;
    while (!w_rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
    d = w_rsp_data;
    w_rsp_ready = 1'b1;
    tick();
    w_rsp_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] d64;

    rst_n = 1'b1;
    req_valid = 0; req_addr = 0; req_size = 0; req_signed = 0; rsp_ready = 0;
    w_req_valid = 0; w_req_addr = 0; w_req_size = 0; w_req_signed = 0; w_rsp_ready = 0;
    mem_rd_valid = 0; mem_rd_data = 0; w_rd_valid = 0; w_rd_data = 0;
    mem_auto = 1; pend32 = 0; pend64 = 0; pend_addr32 = 0; pend_addr64 = 0;
    rd_cnt = 0; w100 = 32'h8899AABB;
    for (int i = 0; i < 4; i++) rd_log[i] = 32'h0;
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    rst_n = 1'b1;
    tick();

    start32(32'h101, SZ_BYTE, 1'b1, lat);
    $display("lb  0x101 -> %h err=%0d lat=%0d", rsp_data, rsp_err, lat);
    check("lb_lat",   64'(lat),       64'd3);
    check("lb_data",  64'(rsp_data),  64'hFFFFFFAA);
    check("lb_err",   64'(rsp_err),   64'd0);
    check("lb_reads", 64'(rd_cnt),    64'd1);
    check("lb_addr",  64'(rd_log[0]), 64'h100);
    finish32();

    start32(32'h101, SZ_BYTE, 1'b0, lat);
    $display("lbu 0x101 -> %h", rsp_data);
    check("lbu_data", 64'(rsp_data), 64'h000000AA);
    finish32();

    start32(32'h103, SZ_BYTE, 1'b0, lat);
    $display("lbu 0x103 -> %h", rsp_data);
    check("lbu3_data", 64'(rsp_data), 64'h00000088);
    finish32();

    start32(32'h103, SZ_BYTE, 1'b1, lat);
    $display("lb  0x103 -> %h", rsp_data);
    check("lb3_data", 64'(rsp_data), 64'hFFFFFF88);
    finish32();

    start32(32'h100, SZ_WORD, 1'b1, lat);
    $display("lw  0x100 -> %h", rsp_data);
    check("lw_data", 64'(rsp_data), 64'h8899AABB);
    finish32();

    w100 = 32'h80017FFF;
    start32(32'h102, SZ_HALF, 1'b1, lat);
    $display("lh  0x102 -> %h", rsp_data);
    check("lh_data", 64'(rsp_data), 64'hFFFF8001);
    finish32();

    start32(32'h102, SZ_HALF, 1'b0, lat);
    $display("lhu 0x102 -> %h", rsp_data);
    check("lhu_data", 64'(rsp_data), 64'h00008001);
    finish32();
    w100 = 32'h8899AABB;

    start32(32'h203, SZ_WORD, 1'b0, lat);
    $display("lw  0x203 -> %h err=%0d lat=%0d reads=%0d", rsp_data, rsp_err, lat, rd_cnt);
`ifdef LOAD_EXT_SPLIT_EN
    check("xw_lat",   64'(lat),       64'd5);
    check("xw_data",  64'(rsp_data),  64'h77665544);
    check("xw_err",   64'(rsp_err),   64'd0);
    check("xw_reads", 64'(rd_cnt),    64'd2);
    check("xw_addr0", 64'(rd_log[0]), 64'h200);
    check("xw_addr1", 64'(rd_log[1]), 64'h204);
`else
    check("xw_lat",   64'(lat),      64'd1);
    check("xw_data",  64'(rsp_data), 64'd0);
    check("xw_err",   64'(rsp_err),  64'd1);
    check("xw_reads", 64'(rd_cnt),   64'd0);
`endif
    finish32();

    start32(32'h101, SZ_HALF, 1'b1, lat);
    $display("lh  0x101 -> %h err=%0d", rsp_data, rsp_err);
`ifdef LOAD_EXT_SPLIT_EN
    check("mh_data", 64'(rsp_data), 64'hFFFF99AA);
    check("mh_err",  64'(rsp_err),  64'd0);
`else
    check("mh_data", 64'(rsp_data), 64'd0);
    check("mh_err",  64'(rsp_err),  64'd1);
`endif
    finish32();

    start32(32'h100, SZ_DWORD, 1'b0, lat);
    $display("ld32 0x100 -> %h err=%0d lat=%0d", rsp_data, rsp_err, lat);
    check("ill_lat",   64'(lat),      64'd1);
    check("ill_err",   64'(rsp_err),  64'd1);
    check("ill_data",  64'(rsp_data), 64'd0);
    check("ill_reads", 64'(rd_cnt),   64'd0);
    finish32();

    start32(32'h200, SZ_WORD, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      $display("stall %0d: valid=%0d data=%h ready=%0d", i, rsp_valid, rsp_data, req_ready);
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_data",  64'(rsp_data),  64'h44332211);
      check("stall_ready", 64'(req_ready), 64'd0);
      tick();
    end
    finish32();
    check("b2b_ready", 64'(req_ready), 64'd1);
    start32(32'h101, SZ_BYTE, 1'b1, lat);
    $display("b2b lb 0x101 -> %h lat=%0d", rsp_data, lat);
    check("b2b_lat",  64'(lat),      64'd3);
    check("b2b_data", 64'(rsp_data), 64'hFFFFFFAA);
    finish32();

    load64(32'h1000, SZ_DWORD, 1'b1, lat, d64);
    $display("ld64 0x1000 -> %h lat=%0d", d64, lat);
    check("ld64_lat",  64'(lat), 64'd3);
    check("ld64_data", d64,      64'h8000000000000001);
    load64(32'h1004, SZ_WORD, 1'b1, lat, d64);
    $display("lw64 0x1004 -> %h", d64);
    check("lw64_data", d64, 64'hFFFFFFFF80000000);
    load64(32'h1004, SZ_WORD, 1'b0, lat, d64);
    $display("lwu64 0x1004 -> %h", d64);
    check("lwu64_data", d64, 64'h0000000080000000);

    mem_auto   = 1'b0;
    req_addr   = 32'h101;
    req_size   = SZ_BYTE;
    req_signed = 1'b1;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    $display("reset in WAIT0: ready=%0d en=%0d addr=%h valid=%0d data=%h err=%0d",
             req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err);
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_en",    64'(mem_rd_en), 64'd0);
    check("abort_addr",  64'(mem_addr),  64'd0);
    check("abort_valid", 64'(rsp_valid), 64'd0);
    check("abort_data",  64'(rsp_data),  64'd0);
    check("abort_err",   64'(rsp_err),   64'd0);
    tick();
    rst_n = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      $display("late valid %0d: rsp_valid=%0d ready=%0d", i, rsp_valid, req_ready);
      check("late_valid", 64'(rsp_valid), 64'd0);
      check("late_ready", 64'(req_ready), 64'd1);
      tick();
    end
    mem_auto = 1'b1;

    start32(32'h101, SZ_BYTE, 1'b0, lat);
    $display("recover lbu 0x101 -> %h lat=%0d", rsp_data, lat);
    check("rec_lat",  64'(lat),      64'd3);
    check("rec_data", 64'(rsp_data), 64'h000000AA);
    finish32();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
